// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/mem/writeback.
// Optional macro CTRL_ILLEGAL_TRAP_EN adds a sticky illegal-instruction trap state (15).
module multicycle_control_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic [3:0] currentState,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] MemtoReg,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ALUOp1,
   output logic       ALUOp0,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic       illegal_instr,
`endif
   output logic [1:0] PCSource
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      LOAD_WB   = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      ALU_WB    = 4'd7,
      JAL       = 4'd8,
      JALR      = 4'd9,
      LUI       = 4'd10,
      AUIPC     = 4'd11,
      UNUSED    = 4'd12,
      EXEC_I    = 4'd13,
      BRANCH    = 4'd14,
      TRAP      = 4'd15
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t state_q;
   state_t state_d;

   // Where DECODE dispatches each opcode class.
   function automatic state_t decode_target(input logic [6:0] op);
      state_t t;
      case (op)
         OP_R:               t = EXEC_R;
         OP_I:               t = EXEC_I;
         OP_LOAD, OP_STORE:  t = MEM_ADDR;
         OP_BRANCH:          t = BRANCH;
         OP_JAL:             t = JAL;
         OP_JALR:            t = JALR;
         OP_LUI:             t = LUI;
         OP_AUIPC:           t = AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
         default:            t = TRAP;
`else
         default:            t = FETCH;
`endif
      endcase
      return t;
   endfunction

   assign currentState = state_q;

   // State register; synchronous reset beats any pending transition or stall.
   always_ff @(posedge clk) begin
      if (reset) state_q <= state_t'(RESET_STATE);
      else       state_q <= state_d;
   end

   // Next-state and Moore output decode (FETCH IR/PC loads gated by mem_ready).
   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 2'b00;
      RegWrite    = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp1      = 1'b0;
      ALUOp0      = 1'b0;
      PCSource    = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
      unique case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
            state_d = decode_target(opcode);
         end
         MEM_ADDR: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = LOAD_WB;
         end
         LOAD_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
            state_d  = FETCH;
         end
         MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXEC_R: begin
            ALUSrcA = 2'b01;
            ALUOp1  = 1'b1;
            state_d = ALU_WB;
         end
         ALU_WB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end
         JAL: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b10;
            PCWrite  = 1'b1;
            PCSource = 2'b01;
            state_d  = FETCH;
         end
         JALR: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            PCWrite  = 1'b1;
            RegWrite = 1'b1;
            MemtoReg = 2'b10;
            state_d  = FETCH;
         end
         LUI: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b10;
            state_d = ALU_WB;
         end
         AUIPC: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
            state_d = ALU_WB;
         end
         UNUSED: begin
            state_d = FETCH;
         end
         EXEC_I: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ALUOp1  = 1'b1;
            state_d = ALU_WB;
         end
         BRANCH: begin
            ALUSrcA     = 2'b01;
            ALUOp0      = 1'b1;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            state_d     = FETCH;
         end
         TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_instr = 1'b1;
            state_d       = TRAP;
`else
            state_d       = FETCH;
`endif
         end
      endcase
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine of the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and mux selects.
- Exports the 4-bit state code that the ALU control decoder consumes:
  - state 6 = R-type execute
  - state 13 = I-type ALU execute
  - state 14 = branch compare
- Stalls on a single-port memory ready handshake.

Parameters:
- RESET_STATE, 4'd0, state loaded on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  IR[6:0]; sampled only in DECODE and MEM_ADDR.
- mem_ready  input  1  memory completes the current read/write this cycle.
- currentState  output  4  state register, to ALU control.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU zero/branch flag.
- IorD  output  1  memory address select: 0 PC, 1 ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  2  write data select: 00 ALUOut, 01 MDR, 10 PC.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  2  ALU A select: 00 PC, 01 regA, 10 OldPC, 11 zero.
- ALUSrcB  output  2  ALU B select: 00 regB, 01 const 4, 10 immediate.
- ALUOp1  output  1  with ALUOp0: 00 add, 01 branch compare, 10 funct decode.
- ALUOp0  output  1  see ALUOp1.
- PCSource  output  2  PC input select: 00 ALU result, 01 ALUOut.
- illegal_instr  output  1  present only with CTRL_ILLEGAL_TRAP_EN.

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a clk edge with reset=1, the state becomes 0 (FETCH). Reset overrides every transition, including a stalled memory state.
- Moore machine: all outputs decode from the state register only, except IRWrite and PCWrite in FETCH, which are gated by mem_ready.
- Every output not listed for a state is 0. After reset, outputs equal the FETCH values.
- Opcode decode in DECODE:
  - 0110011 → 6
  - 0010011 → 13
  - 0000011 / 0100011 → 2
  - 1100011 → 14
  - 1101111 → 8
  - 1100111 → 9
  - 0110111 → 10
  - 0010111 → 11
  - any other opcode → 0 (or 15 when the trap feature is enabled)
- States (code: outputs → next):
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready → 1 if mem_ready, else hold.
  - 1 DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch/JAL target into ALUOut) → opcode decode above.
  - 2 MEM_ADDR: ALUSrcA=01, ALUSrcB=10 → 3 if load, 5 if store.
  - 3 MEM_READ: MemRead=1, IorD=1 → 4 if mem_ready, else hold.
  - 4 LOAD_WB: RegWrite=1, MemtoReg=01 → 0.
  - 5 MEM_WRITE: MemWrite=1, IorD=1 → 0 if mem_ready, else hold.
  - 6 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10 → 7.
  - 7 ALU_WB: RegWrite=1, MemtoReg=00 → 0.
  - 8 JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01 → 0.
  - 9 JALR: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCSource=00, PCWrite=1, RegWrite=1, MemtoReg=10 → 0.
  - 10 LUI: ALUSrcA=11, ALUSrcB=10 → 7.
  - 11 AUIPC: ALUSrcA=10, ALUSrcB=10 → 7.
  - 12 unused: all outputs 0 → 0.
  - 13 EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=10 → 7.
  - 14 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → 0.
  - 15: see Optional Feature.
- MemRead and MemWrite stay asserted continuously while a memory state holds. They are never both 1.
- Latency per instruction with mem_ready always 1:
  - R / I / LUI / AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch / JAL / JALR: 3 cycles
- Each cycle mem_ready=0 in states 0, 3 or 5 adds exactly one cycle.
- mem_ready is ignored in all other states.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to state 15.
  - State 15 drives illegal_instr=1, all other outputs 0, and holds until reset.
  - illegal_instr is 0 in every other state and after reset.
- Undefined:
  - The illegal_instr port is absent.
  - Unrecognised opcodes go to 0 (executed as NOP).
  - State 15, if ever reached, goes to 0.

Test Plan:
- Reset=1 for 2 cycles, mem_ready=1, opcode=0110011 → currentState sequence 0,1,6,7,0; ALUOp=10 in 6; RegWrite=1 only in 7.
- opcode=0000011, mem_ready low for 3 cycles in state 3 → sequence 0,1,2,3,3,3,3,4,0; MemRead and IorD high throughout state 3.
- opcode=1100011 → 0,1,14,0; ALUOp=01 and PCWriteCond=1 only in 14; PCWrite=0 in 14.
- opcode=0010011 then 1100111 back-to-back → 0,1,13,7,0,1,9,0; JALR shows PCWrite=RegWrite=1, MemtoReg=10.
- Reset asserted while in state 5 with mem_ready=0 → next state 0; MemWrite=0 from that cycle; MemRead=1.
- opcode=1111111: with CTRL_ILLEGAL_TRAP_EN → 0,1,15,15…, illegal_instr=1; without it → 0,1,0.
